// File: rtl/three_lane_requant_serializer.sv
// Requantizes three FIR lanes per clock, buffers triplets, emits one serial stream.
// Optional saturation counter port sat_cnt enabled with `define SAT_CNT_EN.
module three_lane_requant_serializer #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  din0,
  input  logic [IN_W-1:0]  din1,
  input  logic [IN_W-1:0]  din2,
  output logic [OUT_W-1:0] dout,
  output logic [1:0]       dout_lane,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overflow,
  output logic [15:0]      drop_cnt
`ifdef SAT_CNT_EN
  ,
  output logic [15:0]      sat_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic signed [IN_W:0] RND =
    (SHIFT > 0) ? (IN_W+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0) : '0;
  localparam logic signed [IN_W:0] MX =
    {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MN =
    {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  // Extra sign bit keeps the rounding add from wrapping.
  function automatic logic signed [IN_W:0] rshift(
    input logic [IN_W-1:0] x
  );
    logic signed [IN_W:0] xe;
    xe = {x[IN_W-1], x};
    return (xe + RND) >>> SHIFT;
  endfunction

  function automatic logic [OUT_W-1:0] rq_val(
    input logic [IN_W-1:0] x
  );
    logic signed [IN_W:0] t;
    t = rshift(x);
    if (t > MX)
      return {1'b0, {(OUT_W-1){1'b1}}};
    else if (t < MN)
      return {1'b1, {(OUT_W-1){1'b0}}};
    else
      return t[OUT_W-1:0];
  endfunction

`ifdef SAT_CNT_EN
  function automatic logic rq_sat(
    input logic [IN_W-1:0] x
  );
    logic signed [IN_W:0] t;
    t = rshift(x);
    return (t > MX) || (t < MN);
  endfunction
`endif

  logic [3*OUT_W-1:0] mem_q [DEPTH];
  logic [3*OUT_W-1:0] wr_data_d;
  logic [3*OUT_W-1:0] head;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]    lane_q, lane_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;

  logic full, empty, wr_en, drop, rd_xfer;
  logic [OUT_W-1:0] lane_word;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign wr_en   = in_valid && !full;
  assign drop    = in_valid && full;
  assign rd_xfer = !empty && dout_ready;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  assign wr_data_d = {rq_val(din2), rq_val(din1), rq_val(din0)};

  always_comb begin
    lane_word = '0;
    unique case (lane_q)
      2'd0:    lane_word = head[OUT_W-1:0];
      2'd1:    lane_word = head[2*OUT_W-1:OUT_W];
      2'd2:    lane_word = head[3*OUT_W-1:2*OUT_W];
      default: lane_word = '0;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    lane_d     = lane_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (wr_en)
      wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_xfer) begin
      if (lane_q == 2'd2) begin
        lane_d   = 2'd0;
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        lane_d = lane_q + 2'd1;
      end
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF)
        drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      lane_q     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      lane_q     <= lane_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is deliberately not reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && wr_en)
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_d;
  end

`ifdef SAT_CNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;
  logic [1:0]  sat_n;
  logic [16:0] sat_sum;

  always_comb begin
    sat_n = {1'b0, rq_sat(din0)} + {1'b0, rq_sat(din1)} +
            {1'b0, rq_sat(din2)};
    sat_sum   = {1'b0, sat_cnt_q} + 17'(sat_n);
    sat_cnt_d = sat_cnt_q;
    if (wr_en)
      sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst)
      sat_cnt_q <= '0;
    else
      sat_cnt_q <= sat_cnt_d;
  end

  assign sat_cnt = sat_cnt_q;
`endif

  assign in_ready   = !full;
  assign dout_valid = !empty;
  assign dout       = empty ? '0 : lane_word;
  assign dout_lane  = lane_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_three_lane_requant_serializer.sv
// Directed bench for three_lane_requant_serializer with an output scoreboard.
// Expected {lane, sample} pairs are queued at drive time and popped on transfer.
module tb_three_lane_requant_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] din0 = '0;
  logic [63:0] din1 = '0;
  logic [63:0] din2 = '0;
  logic [15:0] dout;
  logic [1:0]  dout_lane;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic        overflow;
  logic [15:0] drop_cnt;
`ifdef SAT_CNT_EN
  logic [15:0] sat_cnt;
`endif

  three_lane_requant_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .din0       (din0),
    .din1       (din1),
    .din2       (din2),
    .dout       (dout),
    .dout_lane  (dout_lane),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
`ifdef SAT_CNT_EN
    ,
    .sat_cnt    (sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int pops = 0;
  logic [17:0] sb[$];
  logic        held = 1'b0;
  logic [17:0] held_v = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push3(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c);
    sb.push_back({2'd0, a});
    sb.push_back({2'd1, b});
    sb.push_back({2'd2, c});
  endtask

  task automatic put(input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] c);
    din0 = a;
    din1 = b;
    din2 = c;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      cyc();
      n++;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  // Output monitor: transfers checked against scoreboard, stalls must hold.
  always @(negedge clk) begin
    logic [17:0] e;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held)
        chk("hold", {14'd0, dout_lane, dout}, {14'd0, held_v});
      if (dout_valid && dout_ready) begin
        e = (sb.size() != 0) ? sb.pop_front() : 18'h3FFFF;
        chk("sample", {14'd0, dout_lane, dout}, {14'd0, e});
        pops++;
      end
      held   = dout_valid && !dout_ready;
      held_v = {dout_lane, dout};
    end
  end

  initial begin
    int p0;
    // Reset state
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_lane", dout_lane, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_cnt, 0);

    // Rounding, latency, 3 consecutive samples
    dout_ready = 1'b1;
    push3(16'd1, 16'hFFFF, 16'd1);
    put(64'sd32768, -64'sd32768, 64'sd16384);
    chk("lat_valid", dout_valid, 1);
    chk("lat_lane", dout_lane, 0);
    cyc();
    cyc();
    cyc();
    chk("r1_empty_valid", dout_valid, 0);
    chk("r1_sb", sb.size(), 0);
    push3(16'd0, 16'd0, 16'd0);
    put(-64'sd16384, 64'sd0, 64'sd0);
    drain(10);

    // Saturation, twice
    push3(16'h7FFF, 16'h8000, 16'h0000);
    put(64'sd1 << 40, -(64'sd1 << 40), 64'sd0);
    push3(16'h7FFF, 16'h8000, 16'h0000);
    put(64'sd1 << 40, -(64'sd1 << 40), 64'sd0);
    drain(20);
    chk("sat_ovf", overflow, 0);
`ifdef SAT_CNT_EN
    chk("sat_cnt4", sat_cnt, 4);
`endif
    // Edges of the rounding/saturation boundary
    push3(16'h7FFF, 16'h8000, 16'h8000);
    put((64'sd32767 << 15) + 64'sd16383,
        -(64'sd32768 << 15) - 64'sd16385,
        -(64'sd32768 << 15) - 64'sd16384);
    drain(10);
`ifdef SAT_CNT_EN
    chk("sat_cnt5", sat_cnt, 5);
`endif

    // Backpressure: 6 offered, 4 stored, 2 dropped
    dout_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      din0 = 64'(3 * i + 10) << 15;
      din1 = 64'(3 * i + 11) << 15;
      din2 = 64'(3 * i + 12) << 15;
      if (i == 5)
        din0 = 64'sd1 << 40;
      in_valid = 1'b1;
      chk("bp_in_ready", in_ready, (i < 4) ? 1 : 0);
      if (i < 4)
        push3(16'(3 * i + 10), 16'(3 * i + 11), 16'(3 * i + 12));
      cyc();
    end
    in_valid = 1'b0;
    chk("bp_drop", drop_cnt, 2);
    chk("bp_ovf", overflow, 1);
    p0 = pops;
    dout_ready = 1'b1;
    drain(40);
    chk("bp_count", pops - p0, 12);
    chk("bp_idle", dout_valid, 0);
`ifdef SAT_CNT_EN
    chk("sat_drop", sat_cnt, 5);
`endif

    // Stall stability with alternating ready
    dout_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      push3(16'(100 + 3 * t), 16'(101 + 3 * t), 16'(102 + 3 * t));
      put(64'(100 + 3 * t) << 15, 64'(101 + 3 * t) << 15,
          64'(102 + 3 * t) << 15);
    end
    p0 = pops;
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      dout_ready = (i % 2 == 0);
      cyc();
    end
    chk("stall_count", pops - p0, 9);
    dout_ready = 1'b1;
    drain(4);

    // Reset after two lanes of a triplet
    push3(16'd7, 16'd8, 16'd9);
    put(64'sd7 << 15, 64'sd8 << 15, 64'sd9 << 15);
    cyc();
    cyc();
    chk("mid_lane", dout_lane, 2);
    dout_ready = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    sb.delete();
    chk("mid_valid", dout_valid, 0);
    chk("mid_drop", drop_cnt, 0);
    chk("mid_ovf", overflow, 0);
    dout_ready = 1'b1;
    push3(16'd20, 16'd21, 16'd22);
    put(64'sd20 << 15, 64'sd21 << 15, 64'sd22 << 15);
    chk("post_lane", dout_lane, 0);
    chk("post_valid", dout_valid, 1);
    drain(10);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
